// File: rtl/pla_sched_pkg.sv
// Shared types and sizes for the 65-pair round-robin scheduler.
package pla_sched_pkg;
  localparam int N    = 65;
  localparam int IDXW = $clog2(N);

  typedef enum logic {IDLE, GRANT} sched_state_t;
  typedef logic [N-1:0] pair_vec_t;

  function automatic pair_vec_t onehot_of(input logic [IDXW-1:0] idx);
    pair_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/pla_rr_pick.sv
// Rotating-priority first-one picker: lowest set bit at or above ptr, else lowest set bit overall.
module pla_rr_pick
  import pla_sched_pkg::*;
(
  input  pair_vec_t         vec_i,
  input  logic [IDXW-1:0]   ptr_i,
  output logic              found_o,
  output logic [IDXW-1:0]   idx_o
);
  localparam int PW = $clog2(2*N);

  pair_vec_t         hi_mask;
  logic [2*N-1:0]    dbl;
  logic [PW-1:0]     pos;
  logic [PW-1:0]     adj;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) hi_mask[i] = (IDXW'(i) >= ptr_i);
    // Upper copy is unmasked so the search wraps past N-1 back to 0.
    dbl = {vec_i, vec_i & hi_mask};
    pos = '0;
    for (int i = 2*N-1; i >= 0; i--) if (dbl[i]) pos = PW'(i);
    adj     = (pos >= PW'(N)) ? pos - PW'(N) : pos;
    idx_o   = adj[IDXW-1:0];
    found_o = |vec_i;
  end
endmodule

// File: rtl/pla_pair_rr_sched.sv
// Round-robin grant over eligible = req_i & en_i with valid/ready hold.
// Optional grant lock on handshake when PLA_SCHED_LOCK_EN is defined.
module pla_pair_rr_sched
  import pla_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  pair_vec_t         req_i,
  input  pair_vec_t         en_i,
  output logic              any_o,
  output logic              gnt_valid_o,
  output logic [IDXW-1:0]   gnt_idx_o,
  output pair_vec_t         gnt_onehot_o,
  input  logic              gnt_ready_i
`ifdef PLA_SCHED_LOCK_EN
  ,
  input  logic              lock_i
`endif
);
  pair_vec_t         eligible;
  logic              lock_w;
  logic              hs;
  logic [IDXW-1:0]   ptr_adv, pick_ptr, pick_idx;
  logic              pick_found;

  sched_state_t      state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
  pair_vec_t         gnt_onehot_q, gnt_onehot_d;

`ifdef PLA_SCHED_LOCK_EN
  assign lock_w = lock_i;
`else
  assign lock_w = 1'b0;
`endif

  assign eligible = req_i & en_i;
  assign any_o    = |eligible;
  assign hs       = (state_q == GRANT) && gnt_ready_i;
  assign ptr_adv  = (gnt_idx_q == IDXW'(N-1)) ? '0 : gnt_idx_q + 1'b1;
  // In GRANT the only re-arbitration is at handshake, which already uses the advanced pointer.
  assign pick_ptr = (state_q == GRANT) ? ptr_adv : ptr_q;

  pla_rr_pick u_pick (
    .vec_i   (eligible),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx;
        end
      end
      GRANT: begin
        if (hs && !(lock_w && eligible[gnt_idx_q])) begin
          ptr_d = ptr_adv;
          if (pick_found) begin
            gnt_idx_d = pick_idx;
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_onehot_d = gnt_valid_d ? onehot_of(gnt_idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  assign gnt_valid_o  = gnt_valid_q;
  assign gnt_idx_o    = gnt_idx_q;
  assign gnt_onehot_o = gnt_onehot_q;
endmodule
